// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI register-access sequencer and its arbiter.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND0,
        WAIT1,
        WAIT_RX,
        DONE
    } seq_state_t;

    // Frame layout: byte0 = {WR, addr[6:0]}, byte1 = write data or dummy.
    localparam int         WR_BIT_POS  = 7;
    localparam logic [7:0] DUMMY_BYTE  = 8'h00;
    localparam int         FRAME_BYTES = 2;
    localparam logic [1:0] RD_DATA_IDX = 2'd1;

    // Index width that still works for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Command byte: address in the low bits, direction flag on top.
    function automatic logic [7:0] cmd_byte(input logic wr, input logic [6:0] addr);
        logic [7:0] b;
        b             = {1'b0, addr};
        b[WR_BIT_POS] = wr;
        return b;
    endfunction

endpackage

// File: rtl/spi_reg_sequencer_if.sv
// Requester bus plus SPI-master-wrapper byte bus seen by the sequencer.
interface spi_reg_sequencer_if #(
    parameter int NUM_REQ = 2
);
    // control-plane requesters
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_wr;
    logic [NUM_REQ*7-1:0] req_addr;
    logic [NUM_REQ*8-1:0] req_wdata;
    logic [NUM_REQ-1:0]   req_ack;
    logic [NUM_REQ-1:0]   rsp_dv;
    logic                 rsp_err;
    logic [7:0]           rsp_rdata;

    // SPI master wrapper
    logic [1:0]           spi_tx_count;
    logic [7:0]           spi_tx_byte;
    logic                 spi_tx_dv;
    logic                 spi_tx_ready;
    logic                 spi_rx_dv;
    logic [1:0]           spi_rx_count;
    logic [7:0]           spi_rx_byte;

    // The sequencer owns the frame, so it is the master side.
    modport master (
        input  req, req_wr, req_addr, req_wdata,
        input  spi_tx_ready, spi_rx_dv, spi_rx_count, spi_rx_byte,
        output req_ack, rsp_dv, rsp_err, rsp_rdata,
        output spi_tx_count, spi_tx_byte, spi_tx_dv
    );

    modport slave (
        output req, req_wr, req_addr, req_wdata,
        output spi_tx_ready, spi_rx_dv, spi_rx_count, spi_rx_byte,
        input  req_ack, rsp_dv, rsp_err, rsp_rdata,
        input  spi_tx_count, spi_tx_byte, spi_tx_dv
    );

endinterface

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin arbiter; the caller holds the pointer register.
module spi_rr_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               any_vld
);

    // Search from ptr+1 upward with wrap; the first asserted request wins.
    always_comb begin
        int               j;
        logic [IDX_W-1:0] k;
        gnt     = '0;
        gnt_idx = '0;
        any_vld = 1'b0;
        j       = 0;
        k       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            k = IDX_W'(j);
            if (!any_vld && req[k]) begin
                any_vld = 1'b1;
                gnt_idx = k;
                gnt[k]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_reg_sequencer.sv
// Turns requester register accesses into 2-byte SPI frames on a shared master.
module spi_reg_sequencer
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int TIMEOUT_CLKS = 1024
) (
    input  logic                i_Clk,
    input  logic                i_Rst_L,
    spi_reg_sequencer_if.master bus
);

    localparam int               IDX_W    = idx_width(NUM_REQ);
    localparam int               TMR_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);
    localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);

    seq_state_t         state, state_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [IDX_W-1:0]   gnt_idx, gnt_idx_nxt;
    logic               wr, wr_nxt;
    logic [7:0]         wdata, wdata_nxt;
    logic [TMR_W-1:0]   tmr, tmr_nxt;
    logic [NUM_REQ-1:0] ack_nxt, rsp_dv_nxt, gnt_oh;
    logic               rsp_err_nxt, tx_dv_nxt;
    logic [7:0]         rsp_rdata_nxt, tx_byte_nxt;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    logic [6:0]         addr_arr  [NUM_REQ];
    logic [7:0]         wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = bus.req_addr[7*g +: 7];
        assign wdata_arr[g] = bus.req_wdata[8*g +: 8];
    end

    spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (bus.req),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any_vld (arb_any)
    );

    assign gnt_oh           = NUM_REQ'(1) << gnt_idx;
    assign bus.spi_tx_count = 2'(FRAME_BYTES);

    // FSM state register; an async reset abandons any frame without a response.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state plus next values of every registered output and latch.
    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        gnt_idx_nxt   = gnt_idx;
        wr_nxt        = wr;
        wdata_nxt     = wdata;
        tmr_nxt       = tmr;
        ack_nxt       = '0;
        rsp_dv_nxt    = '0;
        rsp_err_nxt   = bus.rsp_err;
        rsp_rdata_nxt = bus.rsp_rdata;
        tx_dv_nxt     = 1'b0;
        tx_byte_nxt   = bus.spi_tx_byte;
        case (state)
            IDLE: begin
                // Re-gating on ready keeps us off a master still busy after a timeout.
                if (arb_any && bus.spi_tx_ready) begin
                    gnt_idx_nxt = arb_idx;
                    ptr_nxt     = arb_idx;
                    wr_nxt      = bus.req_wr[arb_idx];
                    wdata_nxt   = wdata_arr[arb_idx];
                    ack_nxt     = arb_gnt;
                    tx_dv_nxt   = 1'b1;
                    tx_byte_nxt = cmd_byte(bus.req_wr[arb_idx], addr_arr[arb_idx]);
                    state_nxt   = SEND0;
                end
            end
            SEND0: begin
                // Timer counts cycles since byte0 launch; the SEND0 cycle was the first.
                tmr_nxt   = TMR_W'(1);
                state_nxt = WAIT1;
            end
            WAIT1: begin
                tmr_nxt = tmr + 1'b1;
                if (tmr == TMR_LAST) begin
                    rsp_dv_nxt    = gnt_oh;
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = DUMMY_BYTE;
                    state_nxt     = DONE;
                end else if (bus.spi_tx_ready) begin
                    tx_dv_nxt   = 1'b1;
                    tx_byte_nxt = wr ? wdata : DUMMY_BYTE;
                    state_nxt   = WAIT_RX;
                end
            end
            WAIT_RX: begin
                tmr_nxt = tmr + 1'b1;
                if (bus.spi_rx_dv && (bus.spi_rx_count == RD_DATA_IDX)) begin
                    rsp_dv_nxt    = gnt_oh;
                    rsp_err_nxt   = 1'b0;
                    rsp_rdata_nxt = wr ? DUMMY_BYTE : bus.spi_rx_byte;
                    state_nxt     = DONE;
                end else if (tmr == TMR_LAST) begin
                    rsp_dv_nxt    = gnt_oh;
                    rsp_err_nxt   = 1'b1;
                    rsp_rdata_nxt = DUMMY_BYTE;
                    state_nxt     = DONE;
                end
            end
            DONE: begin
                // Response pulse is out this cycle; arbitration resumes next cycle.
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs, grant latches, RR pointer and timeout counter.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            ptr             <= PTR_RST;
            gnt_idx         <= '0;
            wr              <= 1'b0;
            wdata           <= 8'h00;
            tmr             <= '0;
            bus.req_ack     <= '0;
            bus.rsp_dv      <= '0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_rdata   <= 8'h00;
            bus.spi_tx_dv   <= 1'b0;
            bus.spi_tx_byte <= 8'h00;
        end else begin
            ptr             <= ptr_nxt;
            gnt_idx         <= gnt_idx_nxt;
            wr              <= wr_nxt;
            wdata           <= wdata_nxt;
            tmr             <= tmr_nxt;
            bus.req_ack     <= ack_nxt;
            bus.rsp_dv      <= rsp_dv_nxt;
            bus.rsp_err     <= rsp_err_nxt;
            bus.rsp_rdata   <= rsp_rdata_nxt;
            bus.spi_tx_dv   <= tx_dv_nxt;
            bus.spi_tx_byte <= tx_byte_nxt;
        end
    end

endmodule

// File: doc/spi_reg_sequencer.md
Name: spi_reg_sequencer

Overview:
- Shares one SPI_Master_With_Single_CS instance (MAX_BYTES_PER_CS=2) between NUM_REQ register-access requesters.
- Each request becomes one 2-byte CS-low frame:
  - byte0 = {WR, addr[6:0]}.
  - byte1 = write data, or dummy 8'h00 for a read.
- Read data is the byte received during byte1 and is returned to the granted requester.
- Sits between the control plane (config/status clients) and the SPI master wrapper.

Parameters:
- NUM_REQ, 2, number of requesters (1..8).
- TIMEOUT_CLKS, 1024, max i_Clk cycles from byte0 launch to byte1 RX_DV before abort (>=2).

Ports:
- i_Clk  in  1  system clock.
- i_Rst_L  in  1  reset; asynchronous, active-low.
- i_Req  in  NUM_REQ  per-requester request level; held until matching o_Req_Ack.
- i_Req_Wr  in  NUM_REQ  1=write, 0=read.
- i_Req_Addr  in  NUM_REQ*7  packed register addresses; requester k at [7k+6:7k].
- i_Req_WData  in  NUM_REQ*8  packed write data; requester k at [8k+7:8k].
- o_Req_Ack  out  NUM_REQ  one-cycle accept pulse, one-hot.
- o_Rsp_DV  out  NUM_REQ  one-cycle completion pulse, one-hot.
- o_Rsp_Err  out  1  valid with o_Rsp_DV; 1 = timeout abort.
- o_Rsp_RData  out  8  read data, valid with o_Rsp_DV (reads only; 8'h00 for writes/errors).
- o_SPI_TX_Count  out  2  byte count to wrapper; constant 2.
- o_SPI_TX_Byte  out  8  byte to wrapper.
- o_SPI_TX_DV  out  1  one-cycle byte strobe.
- i_SPI_TX_Ready  in  1  wrapper ready.
- i_SPI_RX_DV  in  1  wrapper received-byte pulse.
- i_SPI_RX_Count  in  2  index of byte flagged by i_SPI_RX_DV (0-based).
- i_SPI_RX_Byte  in  8  received byte.

Behaviour:
- All outputs registered.
- Reset values:
  - o_Req_Ack, o_Rsp_DV, o_Rsp_Err, o_SPI_TX_DV = 0.
  - o_Rsp_RData, o_SPI_TX_Byte = 8'h00.
  - State = IDLE; RR pointer = NUM_REQ-1, so requester 0 wins first.
- States: IDLE, SEND0, WAIT1, WAIT_RX, DONE.
- IDLE: if |i_Req and i_SPI_TX_Ready:
  - Round-robin grant, searching from pointer+1 upward and wrapping.
  - Latch grant index, Wr, Addr, WData; update pointer to grant.
  - Pulse o_Req_Ack[grant] next cycle; go SEND0.
- SEND0: drive o_SPI_TX_DV=1 for exactly one cycle with byte0 = {Wr, Addr}; clear timeout counter; go WAIT1.
- WAIT1: on i_SPI_TX_Ready=1 (first cycle seen high), pulse o_SPI_TX_DV with byte1 (WData if Wr, else 8'h00); go WAIT_RX.
- WAIT_RX: on i_SPI_RX_DV=1 with i_SPI_RX_Count==1, capture i_SPI_RX_Byte (forced 8'h00 if Wr); go DONE.
  - RX_DV with count 0 is ignored.
- DONE: pulse o_Rsp_DV[grant] with o_Rsp_Err=0 and o_Rsp_RData; return to IDLE.
  - No new grant is issued in the DONE cycle; earliest next Ack is 2 cycles after o_Rsp_DV.
- Timeout: counter runs in WAIT1/WAIT_RX. On reaching TIMEOUT_CLKS-1, go DONE with o_Rsp_Err=1 and RData=8'h00.
  - IDLE re-gating on i_SPI_TX_Ready prevents launching into a still-busy master.
- Requests arriving mid-transaction are held (level) and arbitrated at the next IDLE; no queueing inside the block.
- A requester dropping i_Req before Ack is legal; the request is simply not granted.
- Change of Addr/WData after Ack has no effect on the in-flight frame.
- Async reset mid-frame returns to IDLE immediately. The wrapper shares the reset, so CS deasserts; no response pulse is issued.
- o_Req_Ack and o_Rsp_DV are never both high for the same requester in the same cycle; at most one bit of each is set.

Decomposition:
- spi_ctrl_pkg:
  - State encoding.
  - Frame constants: WR_BIT_POS=7, DUMMY_BYTE=8'h00, FRAME_BYTES=2, RD_DATA_IDX=1.
- Sub-module spi_rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded index, any-valid.
  - Combinational with registered pointer held in the sequencer; reused by later SPI clients.

Test Plan:
- Write: req0 Wr=1 Addr=7'h12 WData=8'hA5 -> MOSI frame 8'h92, 8'hA5 under one CS low; o_Rsp_DV[0]=1, Err=0, RData=8'h00.
- Read: req1 Wr=0 Addr=7'h05, slave model returns 8'h3C on byte1 -> MOSI 8'h05, 8'h00; o_Rsp_DV[1] with RData=8'h3C.
- Fairness: req0 and req1 held continuously (NUM_REQ=2) -> Ack order 0,1,0,1 over 4 frames; exactly one frame per CS low; no overlap.
- Timeout: TIMEOUT_CLKS=16, force i_SPI_TX_Ready=0 after byte0 -> o_Rsp_DV with Err=1 and RData=8'h00 at cycle 16 after SEND0; no new grant until TX_Ready returns.
- Reset mid-frame: assert i_Rst_L low during WAIT_RX -> all outputs return to reset values asynchronously; no o_Rsp_DV; after release, req0 is granted first.
- Back-to-back: req0 re-asserts immediately after Ack -> second Ack exactly 2 cycles after the first o_Rsp_DV (with TX_Ready high).
